// File: rtl/seg_pkg.sv
// Shared types and constants for the 8-digit multiplexed seven-segment driver.
// Provides the controller state encoding, the digit code carried through the
// display buffer, glyph patterns (bit0..bit6 = a..g, bit7 = dp, always 0) and
// the BCD register width used by the binary-to-decimal converter.
package seg_pkg;

  localparam int unsigned BCD_W = 40;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StConv   = 2'd1,
    StCommit = 2'd2
  } state_e;

  // One display position: a 4-bit value plus overrides for blank and dash.
  typedef struct packed {
    logic       blank;
    logic       dash;
    logic [3:0] val;
  } digit_t;

  localparam digit_t DIGIT_BLANK = '{blank: 1'b1, dash: 1'b0, val: 4'h0};
  localparam digit_t DIGIT_DASH  = '{blank: 1'b0, dash: 1'b1, val: 4'h0};

  localparam logic [7:0] GLYPH_DASH  = 8'h40;
  localparam logic [7:0] GLYPH_BLANK = 8'h00;

  // Indexed by nibble value; element 15 listed first.
  localparam logic [15:0][7:0] GLYPH_HEX = {
    8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
    8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

  function automatic digit_t digit_val(input logic [3:0] v);
    digit_t d;
    d.blank = 1'b0;
    d.dash  = 1'b0;
    d.val   = v;
    return d;
  endfunction

endpackage

// File: rtl/seg_glyph.sv
// Combinational digit-code to segment-pattern mapping.
// Ports:
//   code    - digit code (value with blank/dash overrides)
//   pattern - active-high segments, bit0..bit6 = a..g, bit7 = dp (always 0)
module seg_glyph
  import seg_pkg::*;
(
  input  digit_t     code,
  output logic [7:0] pattern
);

  always_comb begin
    pattern = GLYPH_BLANK;
    if (code.dash) begin
      pattern = GLYPH_DASH;
    end else if (!code.blank) begin
      pattern = GLYPH_HEX[code.val];
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Eight-digit multiplexed seven-segment driver with hex or unsigned-decimal
// display. Decimal values are converted by a 32-cycle double-dabble and the
// display buffer is only written at the commit edge, so the scanned display
// never shows a partial result.
// Ports:
//   clk_slow - clock, rising edge
//   rst      - synchronous, active-low reset
//   load     - one-cycle display request, ignored while busy
//   data     - value to display, sampled on accepted load
//   dec_mode - 0 = hex, 1 = unsigned decimal, sampled with data
//   busy     - decimal conversion in progress
//   seg      - segment patterns; seg[1] for digits 7..4, seg[0] for digits 3..0
//   seg_sel  - one-hot digit enables; seg_sel[g][k] enables digit 4g+k
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 16
) (
  input  logic            clk_slow,
  input  logic            rst,
  input  logic            load,
  input  logic [31:0]     data,
  input  logic            dec_mode,
  output logic            busy,
  output logic [1:0][7:0] seg,
  output logic [1:0][3:0] seg_sel
);

  localparam logic [15:0] CntMax = 16'(SCAN_DIV - 1);

  state_e             state_q, state_d;
  logic [4:0]         iter_q, iter_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BCD_W-1:0]   bcd_adj;
  logic [31:0]        bin_q, bin_d;
  digit_t [7:0]       disp_q, disp_d;
  digit_t [7:0]       commit_digits;
  logic [15:0]        cnt_q, cnt_d;
  logic [1:0]         k_q, k_d;
  logic [1:0][7:0]    seg_q;
  logic [1:0][3:0]    sel_q;
  logic [7:0]         glyph_lo, glyph_hi;

  assign busy    = (state_q != StIdle);
  assign seg     = seg_q;
  assign seg_sel = sel_q;

  // Double-dabble correction: add 3 to every BCD digit >= 5 before shifting.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end else begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
      end
    end
  end

  // Final digits: dashes on overflow, otherwise blank leading zeros down to
  // digit 1 (digit 0 always shows).
  always_comb begin
    logic overflow;
    logic zero_run;
    overflow      = |bcd_q[39:32];
    zero_run      = 1'b1;
    commit_digits = '0;
    for (int k = 7; k >= 0; k--) begin
      zero_run = zero_run & (bcd_q[4*k +: 4] == 4'h0);
      if (overflow) begin
        commit_digits[k] = DIGIT_DASH;
      end else if (zero_run && (k != 0)) begin
        commit_digits[k] = DIGIT_BLANK;
      end else begin
        commit_digits[k] = digit_val(bcd_q[4*k +: 4]);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    disp_d  = disp_q;
    case (state_q)
      StIdle: begin
        if (load) begin
          if (dec_mode) begin
            state_d = StConv;
            bin_d   = data;
            bcd_d   = '0;
            iter_d  = '0;
          end else begin
            for (int k = 0; k < 8; k++) begin
              disp_d[k] = digit_val(data[4*k +: 4]);
            end
          end
        end
      end
      StConv: begin
        bcd_d  = {bcd_adj[BCD_W-2:0], bin_q[31]};
        bin_d  = {bin_q[30:0], 1'b0};
        iter_d = iter_q + 5'd1;
        if (iter_q == 5'd31) begin
          state_d = StCommit;
        end
      end
      StCommit: begin
        disp_d  = commit_digits;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    k_d   = k_q;
    if (cnt_q >= CntMax) begin
      cnt_d = '0;
      k_d   = k_q + 2'd1;
    end
  end

  // Outputs decode the next-state index and buffer so they line up with the
  // registered k and buffer contents after every edge.
  seg_glyph u_glyph_lo (
    .code    (disp_d[{1'b0, k_d}]),
    .pattern (glyph_lo)
  );

  seg_glyph u_glyph_hi (
    .code    (disp_d[{1'b1, k_d}]),
    .pattern (glyph_hi)
  );

  always_ff @(posedge clk_slow) begin
    if (!rst) begin
      state_q <= StIdle;
      iter_q  <= '0;
      bcd_q   <= '0;
      bin_q   <= '0;
      disp_q  <= {8{DIGIT_BLANK}};
      cnt_q   <= '0;
      k_q     <= '0;
      seg_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      disp_q  <= disp_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      seg_q   <= {glyph_hi, glyph_lo};
      sel_q   <= {2{4'b0001 << k_d}};
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

  logic            clk_slow = 1'b0;
  logic            rst      = 1'b0;
  logic            load     = 1'b0;
  logic [31:0]     data     = '0;
  logic            dec_mode = 1'b0;
  logic            busy;
  logic [1:0][7:0] seg;
  logic [1:0][3:0] seg_sel;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] sb_q[$];

  seg_scan_driver #(.SCAN_DIV(4)) dut (
    .clk_slow (clk_slow),
    .rst      (rst),
    .load     (load),
    .data     (data),
    .dec_mode (dec_mode),
    .busy     (busy),
    .seg      (seg),
    .seg_sel  (seg_sel)
  );

  always #5 clk_slow = ~clk_slow;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic            dec;
    logic [31:0]     val;
    logic [7:0][7:0] exp;  // exp[d] = glyph of digit d
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk_slow);
    @(negedge clk_slow);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      n++;
      tick();
    end
    if (busy) check("wait_idle_timeout", 32'(busy), 32'd0);
  endtask

  // Waits for the edge where k wraps to 0 so the next edge still shows k=0.
  task automatic align_k0();
    logic [3:0] prev;
    int n = 0;
    prev = seg_sel[0];
    tick();
    while (!(seg_sel[0] == 4'b0001 && prev != 4'b0001) && n < 40) begin
      prev = seg_sel[0];
      n++;
      tick();
    end
    if (n >= 40) check("align_k0_timeout", 32'(seg_sel[0]), 32'h1);
  endtask

  // Scoreboard: expected glyphs pushed up front, popped after one full scan.
  task automatic check_display(input string name, input logic [7:0][7:0] exp);
    logic [7:0] got[8];
    for (int d = 0; d < 8; d++) begin
      sb_q.push_back(32'(exp[d]));
      got[d] = 8'hFF;
    end
    for (int c = 0; c < 16; c++) begin
      case (seg_sel[0])
        4'b0001: begin got[0] = seg[0]; got[4] = seg[1]; end
        4'b0010: begin got[1] = seg[0]; got[5] = seg[1]; end
        4'b0100: begin got[2] = seg[0]; got[6] = seg[1]; end
        4'b1000: begin got[3] = seg[0]; got[7] = seg[1]; end
        default: ;
      endcase
      tick();
    end
    for (int d = 0; d < 8; d++) begin
      check($sformatf("%s_digit%0d", name, d), 32'(got[d]), sb_q.pop_front());
    end
  endtask

  initial begin
    int nb;
    logic [3:0] exp_sel;

    vecs[0] = '{1'b0, 32'h1234ABCD, {8'h06, 8'h5B, 8'h4F, 8'h66, 8'h77, 8'h7C, 8'h39, 8'h5E}};
    vecs[1] = '{1'b1, 32'd12345,    {8'h00, 8'h00, 8'h00, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D}};
    vecs[2] = '{1'b1, 32'd0,        {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3F}};
    vecs[3] = '{1'b1, 32'd100000000, {8{8'h40}}};
    vecs[4] = '{1'b1, 32'd99999999, {8{8'h6F}}};
    vecs[5] = '{1'b0, 32'h00000000, {8{8'h3F}}};
    vecs[6] = '{1'b1, 32'hFFFFFFFF, {8{8'h40}}};
    vecs[7] = '{1'b0, 32'hFEDC0987, {8'h71, 8'h79, 8'h5E, 8'h39, 8'h3F, 8'h6F, 8'h7F, 8'h07}};
    vecs[8] = '{1'b1, 32'd10000000, {8'h06, {7{8'h3F}}}};
    vecs[9] = '{1'b1, 32'd7,        {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h07}};

    // Reset state.
    repeat (3) tick();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_seg", 32'(seg), 32'd0);
    check("reset_seg_sel", 32'(seg_sel), 32'd0);

    // Release with a hex load on the very first edge; k is 0 there.
    rst = 1'b1; load = 1'b1; dec_mode = 1'b0; data = 32'h1234ABCD;
    tick();
    load = 1'b0;
    check("first_edge_sel", 32'(seg_sel[0]), 32'h1);
    check("hex_same_edge_seg0", 32'(seg[0]), 32'h5E);
    check("hex_same_edge_seg1", 32'(seg[1]), 32'h66);
    check("hex_busy", 32'(busy), 32'd0);

    // Table-driven loads.
    for (int i = 0; i < 10; i++) begin
      wait_idle();
      if (!vecs[i].dec) align_k0();
      data = vecs[i].val; dec_mode = vecs[i].dec; load = 1'b1;
      tick();
      load = 1'b0;
      if (!vecs[i].dec) begin
        check($sformatf("v%0d_busy", i), 32'(busy), 32'd0);
        check($sformatf("v%0d_seg0_now", i), 32'(seg[0]), 32'(vecs[i].exp[0]));
        check($sformatf("v%0d_seg1_now", i), 32'(seg[1]), 32'(vecs[i].exp[4]));
      end else begin
        nb = 0;
        while (busy && nb < 100) begin
          nb++;
          tick();
        end
        check($sformatf("v%0d_busy_cycles", i), 32'(nb), 32'd33);
      end
      check_display($sformatf("v%0d", i), vecs[i].exp);
    end

    // Hex load attempted during a decimal conversion must be dropped.
    wait_idle();
    data = 32'd99; dec_mode = 1'b1; load = 1'b1;
    tick();
    load = 1'b0;
    repeat (4) tick();
    data = 32'd7; dec_mode = 1'b0; load = 1'b1;
    tick();
    load = 1'b0;
    check("ignored_load_busy", 32'(busy), 32'd1);
    wait_idle();
    check_display("busy_ignore", {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h6F});

    // Reset in the middle of a conversion.
    data = 32'd12345; dec_mode = 1'b1; load = 1'b1;
    tick();
    load = 1'b0;
    repeat (9) tick();
    rst = 1'b0;
    tick();
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_seg", 32'(seg), 32'd0);
    check("midreset_seg_sel", 32'(seg_sel), 32'd0);
    tick();
    check("midreset_seg_sel_hold", 32'(seg_sel), 32'd0);
    rst = 1'b1;

    // Scan sequence after release: k = (n/4) % 4 at the n-th edge.
    for (int n = 1; n <= 20; n++) begin
      tick();
      exp_sel = 4'b0001 << ((n / 4) % 4);
      sb_q.push_back(32'(exp_sel));
      sb_q.push_back(32'(exp_sel));
      check($sformatf("scan%0d_sel0", n), 32'(seg_sel[0]), sb_q.pop_front());
      check($sformatf("scan%0d_sel1", n), 32'(seg_sel[1]), sb_q.pop_front());
    end
    check("post_reset_busy", 32'(busy), 32'd0);
    check_display("post_reset_blank", {8{8'h00}});
    repeat (40) tick();
    check_display("no_stale_result", {8{8'h00}});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
